// File: rtl/rate_bridge_fifo.sv
// -----------------------------------------------------------------------------
// rate_bridge_fifo
//
// Single-clock bridge that carries multi-channel sample words from a producer
// running at an arbitrary rate to a consumer paced by a periodic slow_tick
// strobe. A DEPTH-entry FIFO absorbs rate jitter. The input side uses
// valid/ready backpressure. The output side presents one word per tick, and
// an empty FIFO at tick time is reported and counted as an underrun.
//
// Optional feature macro: RATE_BRIDGE_PREFILL_EN
//   defined   : the FSM starts in FILL after reset and ignores ticks until the
//               FIFO holds at least DEPTH/2 words. Any underrun in RUN sends
//               it back to FILL.
//   undefined : the bridge is permanently in RUN.
//
// Parameters
//   WIDTH     bits per channel sample
//   CHANNELS  channels carried in parallel; all channels share one FIFO entry
//   DEPTH     FIFO entries; must be a power of two and at least 2
//
// Ports
//   fast_clk      single clock for all logic
//   reset         synchronous, active-high reset
//   in_valid      producer has a word on in_data
//   in_ready      bridge accepts a word this cycle (!full && !reset)
//   in_data       channel c occupies bits [c*WIDTH +: WIDTH]
//   slow_tick     one-cycle consumer pacing strobe
//   out_data      registered output word
//   out_strobe    one-cycle pulse; out_data was updated or re-presented
//   underrun      one-cycle pulse alongside out_strobe when the FIFO was empty
//   underrun_cnt  saturating underrun count
//   level         current FIFO occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module rate_bridge_fifo #(
    parameter int WIDTH    = 12,
    parameter int CHANNELS = 2,
    parameter int DEPTH    = 8
) (
    input  logic                        fast_clk,
    input  logic                        reset,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [CHANNELS*WIDTH-1:0]   in_data,
    input  logic                        slow_tick,
    output logic [CHANNELS*WIDTH-1:0]   out_data,
    output logic                        out_strobe,
    output logic                        underrun,
    output logic [15:0]                 underrun_cnt,
    output logic [$clog2(DEPTH):0]      level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    localparam logic [LVL_W-1:0] LEVEL_FULL = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] LEVEL_ONE  = LVL_W'(1);

    // -------------------------------------------------------------------------
    // Occupancy and pointer state
    // -------------------------------------------------------------------------
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [LVL_W-1:0] level_reg;
    logic             out_strobe_reg;
    logic             underrun_reg;
    logic [15:0]      underrun_cnt_reg;

    logic full;
    logic empty;
    logic push;
    logic run_active;   // FSM allows ticks to be processed
    logic tick_run;     // a tick processed this cycle
    logic pop;          // tick with data available
    logic miss;         // tick with the FIFO empty

    assign full  = (level_reg == LEVEL_FULL);
    assign empty = (level_reg == '0);

    // Depends only on registered occupancy and reset. It never looks ahead to
    // a same-cycle pop, so a full FIFO refuses the push even while a tick
    // drains it.
    assign in_ready = !full && !reset;
    assign push     = in_valid && in_ready;

    assign tick_run = slow_tick && run_active;
    // No fall-through: pop decisions use the level before this cycle's push,
    // so a word written at edge N is first visible to a tick at edge N+1.
    assign pop      = tick_run && !empty;
    assign miss     = tick_run && empty;

    // -------------------------------------------------------------------------
    // FILL / RUN control
    // -------------------------------------------------------------------------
`ifdef RATE_BRIDGE_PREFILL_EN
    localparam logic [LVL_W-1:0] LEVEL_HALF = LVL_W'(DEPTH / 2);

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t state_reg;

    always_ff @(posedge fast_clk) begin
        if (reset) begin
            state_reg <= FILL;
        end else begin
            case (state_reg)
                FILL: begin
                    if (level_reg >= LEVEL_HALF) begin
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    // The underrun itself is still pulsed and counted by the
                    // datapath below; this only re-arms the prefill.
                    if (miss) begin
                        state_reg <= FILL;
                    end
                end
                default: state_reg <= FILL;
            endcase
        end
    end

    assign run_active = (state_reg == RUN);
`else
    assign run_active = 1'b1;
`endif

    // -------------------------------------------------------------------------
    // Pointers, level, strobes and underrun counter
    // -------------------------------------------------------------------------
    always_ff @(posedge fast_clk) begin
        if (reset) begin
            wr_ptr_reg       <= '0;
            rd_ptr_reg       <= '0;
            level_reg        <= '0;
            out_strobe_reg   <= 1'b0;
            underrun_reg     <= 1'b0;
            underrun_cnt_reg <= '0;
        end else begin
            // DEPTH is a power of two, so the pointers wrap naturally.
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end

            case ({push, pop})
                2'b10:   level_reg <= level_reg + LEVEL_ONE;
                2'b01:   level_reg <= level_reg - LEVEL_ONE;
                default: level_reg <= level_reg;
            endcase

            out_strobe_reg <= tick_run;
            underrun_reg   <= miss;

            if (miss && (underrun_cnt_reg != 16'hFFFF)) begin
                underrun_cnt_reg <= underrun_cnt_reg + 16'd1;
            end
        end
    end

    assign out_strobe   = out_strobe_reg;
    assign underrun     = underrun_reg;
    assign underrun_cnt = underrun_cnt_reg;
    assign level        = level_reg;

    // -------------------------------------------------------------------------
    // Storage: one RAM per channel, written on push and read into the output
    // register on pop. The registered read maps onto block RAM output regs.
    // On an underrun the output register simply keeps its previous word.
    // -------------------------------------------------------------------------
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
        logic [WIDTH-1:0] mem [DEPTH];
        logic [WIDTH-1:0] sample_reg;

        always_ff @(posedge fast_clk) begin
            if (push) begin
                mem[wr_ptr_reg] <= in_data[gi*WIDTH +: WIDTH];
            end
        end

        always_ff @(posedge fast_clk) begin
            if (reset) begin
                sample_reg <= '0;
            end else if (pop) begin
                sample_reg <= mem[rd_ptr_reg];
            end
        end

        assign out_data[gi*WIDTH +: WIDTH] = sample_reg;
    end

endmodule

// File: tb/tb_rate_bridge_fifo.sv
// -----------------------------------------------------------------------------
// tb_rate_bridge_fifo
//
// Directed testbench for rate_bridge_fifo with WIDTH=12, CHANNELS=2, DEPTH=8.
// Inputs change 1 ns after a rising edge. Outputs are checked at that same
// point, so they reflect the edge that was just taken.
//
// With RATE_BRIDGE_PREFILL_EN defined, only the reset and prefill scenarios
// run. Without it, the remaining flow scenarios run.
// -----------------------------------------------------------------------------
module tb_rate_bridge_fifo;

    localparam int WIDTH    = 12;
    localparam int CHANNELS = 2;
    localparam int DEPTH    = 8;
    localparam int DW       = CHANNELS * WIDTH;

    logic          fast_clk;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          slow_tick;
    logic [DW-1:0] out_data;
    logic          out_strobe;
    logic          underrun;
    logic [15:0]   underrun_cnt;
    logic [3:0]    level;

    int checks;
    int errors;
    bit verbose;

    rate_bridge_fifo #(
        .WIDTH    (WIDTH),
        .CHANNELS (CHANNELS),
        .DEPTH    (DEPTH)
    ) dut (
        .fast_clk     (fast_clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .slow_tick    (slow_tick),
        .out_data     (out_data),
        .out_strobe   (out_strobe),
        .underrun     (underrun),
        .underrun_cnt (underrun_cnt),
        .level        (level)
    );

    initial fast_clk = 1'b0;
    always #5 fast_clk = ~fast_clk;

    // Advance one clock edge and settle; logs one line per cycle when verbose.
    task automatic cycle();
        @(posedge fast_clk);
        #1;
        if (verbose) begin
            $display("t=%0t rst=%0b vld=%0b tick=%0b in=%h | out=%h stb=%0b urun=%0b cnt=%0d lvl=%0d rdy=%0b",
                     $time, reset, in_valid, slow_tick, in_data, out_data,
                     out_strobe, underrun, underrun_cnt, level, in_ready);
        end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_reset();
        reset = 1'b1;
        in_valid = 1'b0;
        slow_tick = 1'b0;
        in_data = '0;
        cycle();
        cycle();
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready_during got %b exp 0", in_ready); end
        reset = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
        checks++; if (level !== 4'd0) begin errors++; $display("FAIL reset_level got %0d exp 0", level); end
        checks++; if (out_data !== 24'h0) begin errors++; $display("FAIL reset_out_data got %h exp 000000", out_data); end
        checks++; if (out_strobe !== 1'b0) begin errors++; $display("FAIL reset_strobe got %b exp 0", out_strobe); end
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL reset_underrun got %b exp 0", underrun); end
        checks++; if (underrun_cnt !== 16'h0) begin errors++; $display("FAIL reset_cnt got %h exp 0000", underrun_cnt); end
    endtask

`ifdef RATE_BRIDGE_PREFILL_EN
    // -------------------------------------------------------------------------
    task automatic test_prefill();
        logic [DW-1:0] w [4];
        for (int i = 0; i < 4; i++) begin
            w[i] = {12'(12'h610 + i), 12'(12'h510 + i)};
        end
        // Three pushes while ticking: FILL ignores every tick.
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data = w[i];
            slow_tick = 1'b1;
            cycle();
            checks++; if (out_strobe !== 1'b0) begin errors++; $display("FAIL prefill_no_strobe_%0d got %b exp 0", i, out_strobe); end
            checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL prefill_no_underrun_%0d got %b exp 0", i, underrun); end
        end
        in_valid = 1'b0;
        repeat (2) begin
            cycle();
            checks++; if (out_strobe !== 1'b0) begin errors++; $display("FAIL prefill_idle_strobe got %b exp 0", out_strobe); end
        end
        checks++; if (level !== 4'd3) begin errors++; $display("FAIL prefill_level3 got %0d exp 3", level); end
        // Fourth push reaches DEPTH/2; the FSM enters RUN on the next edge.
        slow_tick = 1'b0;
        in_valid = 1'b1;
        in_data = w[3];
        cycle();
        checks++; if (level !== 4'd4) begin errors++; $display("FAIL prefill_level4 got %0d exp 4", level); end
        in_valid = 1'b0;
        cycle();
        slow_tick = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            checks++; if (out_data !== w[i]) begin errors++; $display("FAIL prefill_word_%0d got %h exp %h", i, out_data, w[i]); end
            checks++; if (out_strobe !== 1'b1) begin errors++; $display("FAIL prefill_strobe_%0d got %b exp 1", i, out_strobe); end
        end
        // Tick on empty: single underrun, then back in FILL.
        cycle();
        checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL prefill_underrun got %b exp 1", underrun); end
        checks++; if (underrun_cnt !== 16'd1) begin errors++; $display("FAIL prefill_cnt got %0d exp 1", underrun_cnt); end
        checks++; if (out_data !== w[3]) begin errors++; $display("FAIL prefill_hold got %h exp %h", out_data, w[3]); end
        cycle();
        checks++; if (out_strobe !== 1'b0) begin errors++; $display("FAIL prefill_refill_strobe got %b exp 0", out_strobe); end
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL prefill_refill_underrun got %b exp 0", underrun); end
        checks++; if (underrun_cnt !== 16'd1) begin errors++; $display("FAIL prefill_refill_cnt got %0d exp 1", underrun_cnt); end
        slow_tick = 1'b0;
        cycle();
    endtask
`else
    // -------------------------------------------------------------------------
    task automatic test_basic();
        in_valid = 1'b1;
        in_data = {12'h456, 12'h123};
        cycle();
        checks++; if (level !== 4'd1) begin errors++; $display("FAIL basic_level1 got %0d exp 1", level); end
        in_data = {12'hABC, 12'h789};
        cycle();
        checks++; if (level !== 4'd2) begin errors++; $display("FAIL basic_level2 got %0d exp 2", level); end
        in_valid = 1'b0;
        slow_tick = 1'b1;
        cycle();
        checks++; if (out_data !== 24'h456123) begin errors++; $display("FAIL basic_word0 got %h exp 456123", out_data); end
        checks++; if (out_strobe !== 1'b1) begin errors++; $display("FAIL basic_strobe0 got %b exp 1", out_strobe); end
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL basic_underrun0 got %b exp 0", underrun); end
        cycle();
        checks++; if (out_data !== 24'hABC789) begin errors++; $display("FAIL basic_word1 got %h exp abc789", out_data); end
        checks++; if (out_strobe !== 1'b1) begin errors++; $display("FAIL basic_strobe1 got %b exp 1", out_strobe); end
        slow_tick = 1'b0;
        cycle();
        checks++; if (out_strobe !== 1'b0) begin errors++; $display("FAIL basic_strobe_idle got %b exp 0", out_strobe); end
        checks++; if (level !== 4'd0) begin errors++; $display("FAIL basic_level0 got %0d exp 0", level); end
        checks++; if (underrun_cnt !== 16'd0) begin errors++; $display("FAIL basic_cnt got %0d exp 0", underrun_cnt); end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_full();
        logic [DW-1:0] exp_word;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data = {12'(12'h200 + i), 12'(12'h100 + i)};
            cycle();
        end
        checks++; if (level !== 4'd8) begin errors++; $display("FAIL full_level8 got %0d exp 8", level); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready got %b exp 0", in_ready); end
        // Push held with a tick: the push is refused, the tick pops.
        in_data = 24'hEEEDDD;
        slow_tick = 1'b1;
        cycle();
        checks++; if (out_data !== 24'h200100) begin errors++; $display("FAIL full_pop_word got %h exp 200100", out_data); end
        checks++; if (level !== 4'd7) begin errors++; $display("FAIL full_level7 got %0d exp 7", level); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL full_ready_after got %b exp 1", in_ready); end
        slow_tick = 1'b0;
        cycle();
        checks++; if (level !== 4'd8) begin errors++; $display("FAIL full_next_push got %0d exp 8", level); end
        in_valid = 1'b0;
        slow_tick = 1'b1;
        for (int i = 1; i < 8; i++) begin
            exp_word = {12'(12'h200 + i), 12'(12'h100 + i)};
            cycle();
            checks++; if (out_data !== exp_word) begin errors++; $display("FAIL full_drain_%0d got %h exp %h", i, out_data, exp_word); end
        end
        cycle();
        checks++; if (out_data !== 24'hEEEDDD) begin errors++; $display("FAIL full_drain_last got %h exp eeeddd", out_data); end
        slow_tick = 1'b0;
        cycle();
        checks++; if (level !== 4'd0) begin errors++; $display("FAIL full_drained got %0d exp 0", level); end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_underrun();
        slow_tick = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL urun_pulse_%0d got %b exp 1", i, underrun); end
            checks++; if (out_strobe !== 1'b1) begin errors++; $display("FAIL urun_strobe_%0d got %b exp 1", i, out_strobe); end
            checks++; if (out_data !== 24'hEEEDDD) begin errors++; $display("FAIL urun_hold_%0d got %h exp eeeddd", i, out_data); end
        end
        slow_tick = 1'b0;
        cycle();
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL urun_idle got %b exp 0", underrun); end
        checks++; if (underrun_cnt !== 16'd3) begin errors++; $display("FAIL urun_cnt got %0d exp 3", underrun_cnt); end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_push_tick_empty();
        in_valid = 1'b1;
        in_data = {12'h5A5, 12'h3C3};
        slow_tick = 1'b1;
        cycle();
        checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL ptick_underrun got %b exp 1", underrun); end
        checks++; if (level !== 4'd1) begin errors++; $display("FAIL ptick_level got %0d exp 1", level); end
        checks++; if (underrun_cnt !== 16'd4) begin errors++; $display("FAIL ptick_cnt got %0d exp 4", underrun_cnt); end
        checks++; if (out_data !== 24'hEEEDDD) begin errors++; $display("FAIL ptick_no_fallthrough got %h exp eeeddd", out_data); end
        in_valid = 1'b0;
        cycle();
        checks++; if (out_data !== 24'h5A53C3) begin errors++; $display("FAIL ptick_next_word got %h exp 5a53c3", out_data); end
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL ptick_next_underrun got %b exp 0", underrun); end
        checks++; if (level !== 4'd0) begin errors++; $display("FAIL ptick_next_level got %0d exp 0", level); end
        slow_tick = 1'b0;
        cycle();
    endtask

    // -------------------------------------------------------------------------
    task automatic test_saturation();
        verbose = 1'b0;
        slow_tick = 1'b1;
        repeat (70000) cycle();
        verbose = 1'b1;
        checks++; if (underrun_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_cnt got %h exp ffff", underrun_cnt); end
        checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL sat_pulse got %b exp 1", underrun); end
        slow_tick = 1'b0;
        cycle();
        checks++; if (underrun_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_hold got %h exp ffff", underrun_cnt); end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data = {12'(12'h0B0 + i), 12'(12'h0A0 + i)};
            cycle();
        end
        in_valid = 1'b0;
        checks++; if (level !== 4'd5) begin errors++; $display("FAIL rmid_level5 got %0d exp 5", level); end
        reset = 1'b1;
        cycle();
        checks++; if (level !== 4'd0) begin errors++; $display("FAIL rmid_level got %0d exp 0", level); end
        checks++; if (out_data !== 24'h0) begin errors++; $display("FAIL rmid_out_data got %h exp 000000", out_data); end
        checks++; if (underrun_cnt !== 16'h0) begin errors++; $display("FAIL rmid_cnt got %h exp 0000", underrun_cnt); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rmid_ready_in_reset got %b exp 0", in_ready); end
        reset = 1'b0;
        cycle();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rmid_ready got %b exp 1", in_ready); end
        checks++; if (level !== 4'd0) begin errors++; $display("FAIL rmid_level_after got %0d exp 0", level); end
        // Contents were discarded: a tick now is an underrun.
        slow_tick = 1'b1;
        cycle();
        checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL rmid_discarded got %b exp 1", underrun); end
        checks++; if (out_data !== 24'h0) begin errors++; $display("FAIL rmid_out_hold got %h exp 000000", out_data); end
        slow_tick = 1'b0;
        cycle();
    endtask
`endif

    // -------------------------------------------------------------------------
    initial begin
        checks = 0;
        errors = 0;
        verbose = 1'b1;
        reset = 1'b1;
        in_valid = 1'b0;
        slow_tick = 1'b0;
        in_data = '0;

        test_reset();
`ifdef RATE_BRIDGE_PREFILL_EN
        test_prefill();
`else
        test_basic();
        test_full();
        test_underrun();
        test_push_tick_empty();
        test_saturation();
        test_reset_mid();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rate_bridge_fifo.md
# rate_bridge_fifo

- Moves multi-channel sample words from a producer running at an arbitrary rate to a consumer paced by a periodic `slow_tick` strobe.
- Everything runs on one clock: a DEPTH-entry FIFO absorbs rate jitter, with valid/ready backpressure on the input.
- Output is one word per tick; underruns are detected and counted.
- Sits between the audio sample generator and the DAC/VGA sample consumers, replacing two-clock data handoff with a single-clock, tick-paced bridge.

## Interface
Parameters:
- `WIDTH`, 12, bits per channel sample
- `CHANNELS`, 2, number of channels carried in parallel; all channels share one FIFO entry
- `DEPTH`, 8, FIFO entries; power of two, ≥ 2

Ports:
- `fast_clk`  input  1  single clock for all logic
- `reset`  input  1  synchronous, active-high reset
- `in_valid`  input  1  producer has a word on `in_data`
- `in_ready`  output  1  bridge accepts a word this cycle
- `in_data`  input  CHANNELS*WIDTH  channel c occupies bits [c*WIDTH +: WIDTH]
- `slow_tick`  input  1  one-cycle consumer pacing strobe
- `out_data`  output  CHANNELS*WIDTH  registered output word
- `out_strobe`  output  1  one-cycle pulse; `out_data` was updated or re-presented
- `underrun`  output  1  one-cycle pulse alongside `out_strobe` when no word was available
- `underrun_cnt`  output  16  saturating underrun count
- `level`  output  $clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH

## Operation
Handshake and push:
- `in_ready` = !full && !reset. It is combinational from registered occupancy only, with no path from `slow_tick`.
- Push occurs when `in_valid && in_ready`; the word is written at the write pointer.
- Pointers are $clog2(DEPTH) bits and wrap naturally. `level` is tracked explicitly; full is `level==DEPTH`, empty is `level==0`.

Pop on tick:
- Applies when `slow_tick` is high and the FSM is in RUN.
  - Not empty: pop the head into `out_data`.
  - Empty: `out_data` holds its previous value, `underrun` pulses, and `underrun_cnt` increments, saturating at 16'hFFFF.
- `out_strobe` pulses on every tick processed in RUN.

Simultaneous events:
- Push and pop in the same cycle: `level` is unchanged. At full, the push is still refused, because `in_ready` does not look ahead to the pop.
- Push and tick in the same cycle while empty: no fall-through. The tick counts as an underrun and the pushed word is stored (`level` becomes 1).

FSM states:
- FILL: ticks are ignored (no strobe, no underrun). Move to RUN when `level >= DEPTH/2`; see Configuration.
- RUN: normal operation as described above.

Reset:
- Reset forces `out_data=0`, `out_strobe=0`, `underrun=0`, `underrun_cnt=0`, `level=0`, pointers 0.
- FSM enters FILL when `RATE_BRIDGE_PREFILL_EN` is defined, RUN otherwise.
- Reset asserted mid-operation discards the FIFO contents in that same cycle.

## Timing
- Tick sampled at edge N: `out_data`, `out_strobe` and `underrun` are valid after edge N, i.e. one cycle of latency.
- A word pushed at edge N can be popped by a tick sampled at edge N+1 at the earliest.
- `level` and `in_ready` reflect a push or pop on the cycle after the edge that performed it.
- Ticks closer together than 1 cycle are impossible by definition. Back-to-back ticks (every cycle) must be supported.

## Configuration
`RATE_BRIDGE_PREFILL_EN`

Defined:
- FSM starts in FILL after reset and reaches RUN at `level >= DEPTH/2`.
- Any underrun in RUN returns the FSM to FILL on the next cycle. The underrun itself is still pulsed and counted once.

Not defined:
- FSM is permanently RUN; the FILL state is compiled out.
- Underruns hold the last value and operation continues.

## Test plan
- **Basic flow:** WIDTH=12, CHANNELS=2, DEPTH=8, macro off. Push 0x123/0x456 then 0x789/0xABC, then two ticks → `out_data` = {0x456,0x123} then {0xABC,0x789}; `out_strobe` pulses twice; `underrun_cnt`=0.
- **Full backpressure:** push 8 words with no ticks → `level`=8, `in_ready`=0. Hold `in_valid` and tick once in the same cycle → no push that cycle, `level`=7, next push accepted.
- **Underrun:** empty FIFO, 3 ticks → 3 `underrun` pulses, `out_data` holds the last value, `underrun_cnt`=3. Preload the count near 16'hFFFF by ticking 70000 times → it saturates at 16'hFFFF.
- **Same-cycle push+tick when empty:** → `underrun`=1, `level`=1 afterwards. The next tick outputs the pushed word.
- **Prefill (macro on), DEPTH=8:**
  - 3 words pushed and ticks applied → no strobes.
  - 4th push → RUN; the next tick outputs word 0.
  - Drain to empty plus one more tick → underrun counted once, FSM back in FILL.
- **Reset mid-stream:** `level`=5, assert `reset` one cycle → all outputs 0, `level`=0, `in_ready`=1 the cycle after deassertion.
